msrv32_pc_gen: RTL

//  Registered program-counter generator for the RV32 fetch stage; successor to the combinational PC mux.

---
 rtl/msrv32_pkg.sv | 22 ++
 rtl/msrv32_pc_target_sel.sv | 62 ++++++
 rtl/msrv32_pc_gen.sv | 114 +++++++++++
 3 files changed

// File: rtl/msrv32_pkg.sv
// Shared definitions for the RV32 fetch-stage program-counter generator:
// PC source encodings, FSM state encoding and buffered-redirect kinds.
package msrv32_pkg;

    localparam logic [1:0] PC_SRC_BOOT = 2'b00;
    localparam logic [1:0] PC_SRC_EPC  = 2'b01;
    localparam logic [1:0] PC_SRC_TRAP = 2'b10;
    localparam logic [1:0] PC_SRC_NEXT = 2'b11;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HOLD = 1'b1
    } pc_state_e;

    // A held BOOT or TRAP/EPC redirect outranks a later branch.
    typedef enum logic [1:0] {
        RDR_BRANCH = 2'b00,
        RDR_PRIV   = 2'b01,
        RDR_BOOT   = 2'b10
    } rdr_kind_e;

endpackage

// File: rtl/msrv32_pc_target_sel.sv
// Combinational next-PC target select with alignment masking, sequential
// step computation and misaligned-branch detection.
module msrv32_pc_target_sel
    import msrv32_pkg::*;
#(
    parameter int                XLEN         = 32,
    parameter logic [XLEN-1:0]   BOOT_ADDRESS = '0,
    parameter int                IALIGN       = 32
) (
    input  logic [1:0]      pc_src_i,
    input  logic [XLEN-1:0] epc_i,
    input  logic [XLEN-1:0] trap_address_i,
    input  logic            branch_taken_i,
    input  logic [XLEN-1:1] iaddr_i,
    input  logic            instr_compressed_i,
    input  logic [XLEN-1:0] pc_i,
    output logic [XLEN-1:0] target_o,
    output logic [XLEN-1:0] pc_plus_step_o,
    output logic            redirect_o,
    output logic            misaligned_o,
    output rdr_kind_e       kind_o
);

    // EPC/TRAP targets lose bit1 as well when only 32-bit instructions exist.
    localparam logic [XLEN-1:0] PRIV_MASK = (IALIGN == 32) ? ~XLEN'(3) : ~XLEN'(1);

    logic [XLEN-1:0] step;
    logic [XLEN-1:0] target_raw;

    assign step           = ((IALIGN == 16) && instr_compressed_i) ? XLEN'(2) : XLEN'(4);
    assign pc_plus_step_o = pc_i + step;

    always_comb begin
        target_raw = pc_plus_step_o;
        kind_o     = RDR_BRANCH;
        case (pc_src_i)
            PC_SRC_BOOT: begin
                target_raw = BOOT_ADDRESS;
                kind_o     = RDR_BOOT;
            end
            PC_SRC_EPC: begin
                target_raw = epc_i & PRIV_MASK;
                kind_o     = RDR_PRIV;
            end
            PC_SRC_TRAP: begin
                target_raw = trap_address_i & PRIV_MASK;
                kind_o     = RDR_PRIV;
            end
            default: begin
                if (branch_taken_i) begin
                    target_raw = {iaddr_i, 1'b0};
                end
            end
        endcase
    end

    assign target_o     = target_raw & ~XLEN'(1);
    assign redirect_o   = (pc_src_i != PC_SRC_NEXT) || branch_taken_i;
    assign misaligned_o = (IALIGN == 32) && (pc_src_i == PC_SRC_NEXT)
                          && branch_taken_i && iaddr_i[1];

endmodule

// File: rtl/msrv32_pc_gen.sv
// Registered program counter for the RV32 fetch stage: holds across AHB wait
// states and buffers a redirect that arrives while the bus is stalled.
module msrv32_pc_gen
    import msrv32_pkg::*;
#(
    parameter int                XLEN         = 32,
    parameter logic [XLEN-1:0]   BOOT_ADDRESS = '0,
    parameter int                IALIGN       = 32
) (
    input  logic            clk_in,
    input  logic            rst_n_in,
    input  logic [1:0]      pc_src_in,
    input  logic [XLEN-1:0] epc_in,
    input  logic [XLEN-1:0] trap_address_in,
    input  logic            branch_taken_in,
    input  logic [XLEN-1:1] iaddr_in,
    input  logic            instr_compressed_in,
    input  logic            ahb_ready_in,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] iaddr_out,
    output logic [XLEN-1:0] pc_plus_step_out,
    output logic            misaligned_instr_out,
    output logic            redirect_pending_out
);

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] rdr_q, rdr_d;
    rdr_kind_e       rdr_kind_q, rdr_kind_d;
    pc_state_e       state_q, state_d;
    logic            mis_q, mis_d;

    logic [XLEN-1:0] target;
    logic            redirect;
    logic            misaligned;
    rdr_kind_e       kind;
    logic            overwrite_ok;
    logic [XLEN-1:0] hold_sel;

    msrv32_pc_target_sel #(
        .XLEN         (XLEN),
        .BOOT_ADDRESS (BOOT_ADDRESS),
        .IALIGN       (IALIGN)
    ) u_target_sel (
        .pc_src_i           (pc_src_in),
        .epc_i              (epc_in),
        .trap_address_i     (trap_address_in),
        .branch_taken_i     (branch_taken_in),
        .iaddr_i            (iaddr_in),
        .instr_compressed_i (instr_compressed_in),
        .pc_i               (pc_q),
        .target_o           (target),
        .pc_plus_step_o     (pc_plus_step_out),
        .redirect_o         (redirect),
        .misaligned_o       (misaligned),
        .kind_o             (kind)
    );

    // A branch may only replace a buffered branch; BOOT/TRAP/EPC replace anything.
    assign overwrite_ok = redirect && !((kind == RDR_BRANCH) && (rdr_kind_q != RDR_BRANCH));
    assign hold_sel     = overwrite_ok ? target : rdr_q;

    always_comb begin
        pc_d       = pc_q;
        rdr_d      = rdr_q;
        rdr_kind_d = rdr_kind_q;
        state_d    = state_q;
        mis_d      = misaligned;
        if (!misaligned) begin
            case (state_q)
                ST_RUN: begin
                    if (ahb_ready_in) begin
                        pc_d = target;
                    end else if (redirect) begin
                        rdr_d      = target;
                        rdr_kind_d = kind;
                        state_d    = ST_HOLD;
                    end
                end
                default: begin
                    if (overwrite_ok) begin
                        rdr_d      = target;
                        rdr_kind_d = kind;
                    end
                    if (ahb_ready_in) begin
                        pc_d    = hold_sel;
                        state_d = ST_RUN;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            pc_q       <= BOOT_ADDRESS;
            rdr_q      <= '0;
            rdr_kind_q <= RDR_BRANCH;
            state_q    <= ST_RUN;
            mis_q      <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            rdr_q      <= rdr_d;
            rdr_kind_q <= rdr_kind_d;
            state_q    <= state_d;
            mis_q      <= mis_d;
        end
    end

    assign pc_out               = pc_q;
    assign iaddr_out            = pc_q;
    assign misaligned_instr_out = mis_q;
    assign redirect_pending_out = (state_q == ST_HOLD);

endmodule
